// File: rtl/stdp_learn_scheduler.sv
// Serial STDP learning/activation engine: one shared datapath visits every
// synapse once per epoch, accumulating activation and updating weight/trace.
module stdp_learn_scheduler #(
    parameter  int N_SYN        = 8,
    parameter  int W            = 8,
    parameter  int DELTA_OFFSET = 4,
    parameter  int DECAY_SHIFT  = 1,
    localparam int AW           = $clog2(N_SYN),
    localparam int SW           = W + AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             learn,
    input  logic             post_spike,
    input  logic [N_SYN-1:0] pre_spike,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W-1:0]     cfg_wdata,
    output logic [W-1:0]     cfg_rdata,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    sum_out,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic [SW-1:0]    acc_q;
    logic [SW-1:0]    sum_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;
    logic [N_SYN-1:0] preL_q;
    logic             postL_q;
    logic             learnL_q;
    logic [W-1:0]     w_q  [N_SYN];
    logic [W-1:0]     tr_q [N_SYN];

    logic [W-1:0]        curW;
    logic [W-1:0]        curTr;
    logic signed [W+1:0] wSum;
    logic [W-1:0]        wClamp_d;
    logic [W-1:0]        trNext_d;
    logic [SW-1:0]       accNext_d;

    // Shared datapath for the synapse currently addressed by idx_q; the
    // W+2-bit signed sum exposes both underflow (sign) and overflow (bit W).
    always_comb begin
        curW      = w_q[idx_q];
        curTr     = tr_q[idx_q];
        wSum      = $signed({2'b00, curW}) + $signed({2'b00, curTr})
                    - $signed((W+2)'(DELTA_OFFSET));
        wClamp_d  = wSum[W-1:0];
        if (wSum[W+1]) begin
            wClamp_d = '0;
        end else if (wSum[W]) begin
            wClamp_d = '1;
        end
        trNext_d  = preL_q[idx_q] ? {W{1'b1}} : (curTr >> DECAY_SHIFT);
        accNext_d = acc_q + (preL_q[idx_q] ? SW'(curW) : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            preL_q    <= '0;
            postL_q   <= 1'b0;
            learnL_q  <= 1'b0;
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i]  <= '0;
                tr_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Host writes land before a coincident tick, so the scan sees them.
                    if (cfg_we) begin
                        w_q[cfg_addr] <= cfg_wdata;
                    end
                    if (tick) begin
                        preL_q   <= pre_spike;
                        postL_q  <= post_spike;
                        learnL_q <= learn;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        overrun_q <= 1'b1;
                    end
                    acc_q <= accNext_d;
                    if (learnL_q) begin
                        tr_q[idx_q] <= trNext_d;
                        if (postL_q) begin
                            w_q[idx_q] <= wClamp_d;
                        end
                    end
                    if (idx_q == AW'(N_SYN - 1)) begin
                        sum_q   <= accNext_d;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                FINISH: begin
                    if (tick) begin
                        overrun_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_rdata = w_q[cfg_addr];
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_stdp_learn_scheduler.sv
// Randomized and directed bench for stdp_learn_scheduler, checked against a
// per-epoch arithmetic model of weights, traces and activation sums.
module tb_stdp_learn_scheduler;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int SW = W + AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          learn;
    logic          post_spike;
    logic [N-1:0]  pre_spike;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_wdata;
    logic [W-1:0]  cfg_rdata;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum_out;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int mw  [N];
    int mtr [N];
    int expSum = 0;
    bit expOverrun = 1'b0;

    stdp_learn_scheduler #(
        .N_SYN(N), .W(W), .DELTA_OFFSET(4), .DECAY_SHIFT(1)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .learn(learn),
        .post_spike(post_spike), .pre_spike(pre_spike), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .busy(busy), .done(done), .sum_out(sum_out), .overrun(overrun)
    );

    // 20-unit clock period leaves room for several #1 read-back probes per cycle.
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Whole-epoch behaviour: sum of pre-spiking weights, then learning rules.
    function automatic int modelEpoch(input logic [N-1:0] pre, input bit post, input bit lrn);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int v;
            if (pre[i]) s += mw[i];
            if (lrn && post) begin
                v = mw[i] + mtr[i] - 4;
                mw[i] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
            end
            if (lrn) mtr[i] = pre[i] ? 255 : mtr[i] / 2;
        end
        return s;
    endfunction

    task automatic checkWeights(input string tag);
        for (int i = 0; i < N; i++) begin
            cfg_addr = AW'(i);
            #1;
            checkOutput($sformatf("%s_w%0d", tag, i), int'(cfg_rdata), mw[i]);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++) begin
            mw[i]  = 0;
            mtr[i] = 0;
        end
        expSum     = 0;
        expOverrun = 1'b0;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        clearModel();
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_sum"}, int'(sum_out), 0);
        checkOutput({tag, "_overrun"}, int'(overrun), 0);
        checkWeights(tag);
    endtask

    task automatic writeWeight(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = W'(d);
        step();
        cfg_we = 1'b0;
        mw[a]  = d;
    endtask

    // One full epoch with cycle-by-cycle timing checks; live inputs are
    // scrambled after the tick so only the latched copies may matter.
    task automatic applyStimulus(input logic [N-1:0] pre, input bit post, input bit lrn,
                                 input bit disturb, input bit cfgTick,
                                 input int cfgA, input int cfgD, input string tag);
        int expNew;
        tick       = 1'b1;
        pre_spike  = pre;
        post_spike = post;
        learn      = lrn;
        if (cfgTick) begin
            cfg_we    = 1'b1;
            cfg_addr  = AW'(cfgA);
            cfg_wdata = W'(cfgD);
            mw[cfgA]  = cfgD;
        end
        step();
        tick       = 1'b0;
        cfg_we     = 1'b0;
        pre_spike  = N'($urandom);
        post_spike = 1'($urandom);
        learn      = 1'($urandom);
        expNew = modelEpoch(pre, post, lrn);
        checkOutput({tag, "_busyStart"}, int'(busy), 1);
        for (int k = 1; k <= N; k++) begin
            if (disturb && k == 3) begin
                tick       = 1'b1;
                cfg_we     = 1'b1;
                cfg_addr   = AW'(1);
                cfg_wdata  = W'(99);
                expOverrun = 1'b1;
            end
            step();
            tick   = 1'b0;
            cfg_we = 1'b0;
            if (k < N) begin
                checkOutput({tag, "_busyScan"}, int'(busy), 1);
                checkOutput({tag, "_doneScan"}, int'(done), 0);
                checkOutput({tag, "_sumHold"}, int'(sum_out), expSum);
            end
        end
        checkOutput({tag, "_doneFinish"}, int'(done), 1);
        checkOutput({tag, "_busyFinish"}, int'(busy), 1);
        checkOutput({tag, "_sum"}, int'(sum_out), expNew);
        expSum = expNew;
        step();
        checkOutput({tag, "_busyIdle"}, int'(busy), 0);
        checkOutput({tag, "_doneIdle"}, int'(done), 0);
        checkOutput({tag, "_sumIdle"}, int'(sum_out), expSum);
        checkOutput({tag, "_overrun"}, int'(overrun), int'(expOverrun));
        checkWeights(tag);
    endtask

    initial begin
        reset      = 1'b0;
        tick       = 1'b0;
        learn      = 1'b0;
        post_spike = 1'b0;
        pre_spike  = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        clearModel();

        doReset("reset");

        for (int i = 0; i < N; i++) writeWeight(i, 10 * (i + 1));
        checkWeights("preload");
        applyStimulus(8'b0000_0101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "noLearn");

        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "traceLoad");
        writeWeight(0, 200);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "potentiate");

        doReset("reset2");
        writeWeight(3, 2);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "floor");
        writeWeight(3, 50);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "depress");

        applyStimulus(8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "decayLoad");
        for (int e = 0; e < 3; e++) applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "decay");
        applyStimulus(8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "decayProbe");

        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "overrun");

        tick       = 1'b1;
        pre_spike  = 8'hFF;
        post_spike = 1'b1;
        learn      = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        clearModel();
        checkOutput("midReset_busy", int'(busy), 0);
        checkOutput("midReset_done", int'(done), 0);
        checkOutput("midReset_sum", int'(sum_out), 0);
        checkOutput("midReset_overrun", int'(overrun), 0);
        checkWeights("midReset");
        for (int i = 0; i < N; i++) writeWeight(i, 5 + 3 * i);
        applyStimulus(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "postReset");

        for (int e = 0; e < 40; e++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) writeWeight(i, int'($urandom_range(0, 255)));
            end
            applyStimulus(N'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                          1'($urandom), int'($urandom_range(0, N - 1)),
                          int'($urandom_range(0, 255)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
